// File: rtl/quad_decoder_counter.sv
// quad_decoder_counter
//   Quadrature decoder for a two-phase Gray-coded encoder pair (a, b).
//   Each pin is synchronised, then every clk cycle the synchronised pair is
//   compared with the previous pair. A single-bit change along the up or
//   down sequence becomes a step of a modulo 2^WIDTH position counter. A
//   double-bit change is illegal and sets a sticky error flag.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   INIT  | synchronisers filling after reset; prev captured on the last cycle
//   RUN   | decode s against prev every cycle
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset, highest priority
//   a, b   encoder phases, asynchronous to clk
//   clr    synchronous clear of count and err
//   count  current position (WIDTH bits)
//   dir    direction of the last legal step (1 = up, 0 = down)
//   step   one-cycle pulse per legal step
//   wrap   one-cycle pulse when count wraps in either direction
//   err    sticky illegal-transition flag
module quad_decoder_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             wrap,
    output logic             err
);

    localparam int               CNT_W     = 3;
    // The chain is cleared by reset, so s only carries the real pin level
    // after SYNC_STAGES edges; prev is captured on the edge after that.
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SYNC_STAGES);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic [1:0]             prev_q, prev_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   dir_q, dir_d;
    logic                   step_q, step_d;
    logic                   wrap_q, wrap_d;
    logic                   err_q, err_d;

    logic                   init_done;
    logic [1:0]             s;
    logic [1:0]             pos_s, pos_prev, delta;
    logic                   is_up, is_down, is_illegal;

    assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Map the Gray pair onto its position in the up sequence 00,10,11,01 so
    // the 2-bit difference gives direction: 1 = up, 3 = down, 2 = illegal.
    assign pos_s      = {s[0], s[1] ^ s[0]};
    assign pos_prev   = {prev_q[0], prev_q[1] ^ prev_q[0]};
    assign delta      = pos_s - pos_prev;
    assign is_up      = (delta == 2'd1);
    assign is_down    = (delta == 2'd3);
    assign is_illegal = (delta == 2'd2);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_done  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    init_done = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output / datapath logic
    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], a};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], b};
        prev_d   = prev_q;
        count_d  = count_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            ST_INIT: begin
                if (init_done) begin
                    prev_d = s;
                end
            end
            default: begin
                prev_d = s;
                if (is_up) begin
                    count_d = count_q + WIDTH'(1);
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                    wrap_d  = &count_q;
                end else if (is_down) begin
                    count_d = count_q - WIDTH'(1);
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                    wrap_d  = ~|count_q;
                end else if (is_illegal) begin
                    err_d = 1'b1;
                end
            end
        endcase

        // clr overrides count/err/wrap but leaves step, dir and prev alone so
        // the decoded step is neither lost nor repeated next cycle.
        if (clr) begin
            count_d = '0;
            err_d   = 1'b0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            prev_q     <= 2'b00;
            count_q    <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            init_cnt_q <= init_cnt_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Bench for quad_decoder_counter with WIDTH=4, SYNC_STAGES=2.
// Pins are driven and outputs sampled on the falling edge of clk.
module tb_quad_decoder_counter;

    localparam int W  = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a   = 1'b0;
    logic         b   = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] count;
    logic         dir, step, wrap, err;

    always #5 clk = ~clk;

    quad_decoder_counter #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .clr   (clr),
        .count (count),
        .dir   (dir),
        .step  (step),
        .wrap  (wrap),
        .err   (err)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] prev_cnt;

    typedef struct {
        logic [1:0] pins;
        logic       clr;
        logic [3:0] cnt;
        logic       dir;
        logic       stp;
        logic       wrp;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Position of each pin pair in the up sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_at(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int gpos(input logic [1:0] p);
        for (int i = 0; i < 4; i++)
            if (gray_at(i) == p) return i;
        return 0;
    endfunction

    function automatic void add(input logic [1:0] p, input logic c, input int ec,
                                input logic ed, input logic es, input logic ew, input logic ee);
        vec_t v;
        v.pins = p; v.clr = c; v.cnt = 4'(ec); v.dir = ed; v.stp = es; v.wrp = ew; v.er = ee;
        vecs.push_back(v);
    endfunction

    // Reset with pins held at p, then watch INIT and idle cycles.
    task automatic do_reset(input logic [1:0] p, input int n, input string nm);
        a = p[1]; b = p[0]; rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        prev_cnt = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk({nm, "_step"},  step,  0);
            chk({nm, "_count"}, count, 0);
            chk({nm, "_err"},   err,   0);
        end
        chk({nm, "_dir"},  dir,  0);
        chk({nm, "_wrap"}, wrap, 0);
    endtask

    // Change pins at a falling edge; result must appear after the third
    // rising edge (pin capture, sync stage 2, decode). Optional clr lands
    // exactly on the decode edge.
    task automatic apply_move(input logic [1:0] p, input logic c, input logic [3:0] ec,
                              input logic ed, input logic es, input logic ew, input logic ee,
                              input int hold, input string nm);
        int ns, nw;
        a = p[1]; b = p[0];
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk({nm, "_lat_count"}, count, prev_cnt);
            chk({nm, "_lat_step"},  step,  0);
        end
        clr = c;
        @(negedge clk);
        clr = 1'b0;
        chk({nm, "_count"}, count, ec);
        chk({nm, "_step"},  step,  es);
        chk({nm, "_wrap"},  wrap,  ew);
        chk({nm, "_dir"},   dir,   ed);
        chk({nm, "_err"},   err,   ee);
        ns = 0; nw = 0;
        for (int i = 3; i < hold; i++) begin
            @(negedge clk);
            ns += int'(step);
            nw += int'(wrap);
        end
        chk({nm, "_extra_steps"}, ns, 0);
        chk({nm, "_extra_wraps"}, nw, 0);
        chk({nm, "_hold_count"},  count, ec);
        chk({nm, "_hold_err"},    err,   ee);
        prev_cnt = ec;
    endtask

    initial begin
        int   m_cnt, d, hold;
        logic m_dir, m_err, c, es, ew;
        logic [1:0] m_pins, np;

        // Directed table: up x12, down x13 (wrap at 0->15), up wrap,
        // illegal 00->11, 5 ups with err held, 2 downs, clr on a step,
        // then 7 ups to reach count 7 with pins at 10.
        for (int i = 0; i < 12; i++) add(gray_at(i + 1), 0, i + 1, 1, 1, 0, 0);
        for (int j = 0; j < 13; j++) add(gray_at(16 + 12 - (j + 1)), 0, (16 + 12 - (j + 1)) % 16, 0, 1, (j == 12), 0);
        add(gray_at(0), 0, 0, 1, 1, 1, 0);
        add(2'b11, 0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 5; k++) add(gray_at(2 + k + 1), 0, k + 1, 1, 1, 0, 1);
        add(gray_at(2), 0, 4, 0, 1, 0, 1);
        add(gray_at(1), 0, 3, 0, 1, 0, 1);
        add(gray_at(2), 1, 0, 1, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(gray_at(2 + k + 1), 0, k + 1, 1, 1, 0, 0);

        do_reset(2'b11, 2, "t1");
        do_reset(2'b00, 2, "rst00");

        foreach (vecs[i])
            apply_move(vecs[i].pins, vecs[i].clr, vecs[i].cnt, vecs[i].dir,
                       vecs[i].stp, vecs[i].wrp, vecs[i].er, 4, $sformatf("v%0d", i));

        do_reset(2'b10, 1, "t6");
        apply_move(2'b11, 0, 4'd1, 1, 1, 0, 0, 4, "t6_first");

        m_cnt = 1; m_dir = 1'b1; m_err = 1'b0; m_pins = 2'b11;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: d = 1;
                4, 5, 6, 7: d = 3;
                8:          d = 0;
                default:    d = 2;
            endcase
            np = gray_at(gpos(m_pins) + d);
            c  = ($urandom_range(0, 7) == 0);
            es = 1'b0; ew = 1'b0;
            if (d == 1) begin
                es = 1'b1; m_dir = 1'b1; ew = (m_cnt == 15); m_cnt = (m_cnt + 1) % 16;
            end else if (d == 3) begin
                es = 1'b1; m_dir = 1'b0; ew = (m_cnt == 0);  m_cnt = (m_cnt + 15) % 16;
            end else if (d == 2) begin
                m_err = 1'b1;
            end
            if (c) begin
                m_cnt = 0; m_err = 1'b0; ew = 1'b0;
            end
            m_pins = np;
            hold = $urandom_range(4, 7);
            apply_move(np, c, 4'(m_cnt), m_dir, es, ew, m_err, hold, $sformatf("r%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
